moxie_ifetch_wb: RTL and testbench

- Instruction fetch stage upstream of the boot ROM and any other Wishbone instruction slave.
- Acts as a Wishbone master: issues 32-bit reads at halfword-aligned addresses.
- Each ack returns two 16-bit halfwords; both are buffered in a halfword FIFO.
- Presents a valid/ready 16-bit instruction-halfword stream, with the address of each halfword, to the moxie decoder. Supports redirect (flush) on branch.

---
 rtl/moxie_ifetch_wb.sv | 161 ++++++++++++++++
 tb/tb_moxie_ifetch_wb.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/moxie_ifetch_wb.sv
// Wishbone instruction-fetch master feeding a halfword FIFO and a valid/ready stream.
// Optional fetch timeout with sticky error and HALT state: define FETCH_TIMEOUT_EN.
module moxie_ifetch_wb #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        wb_tga_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic [15:0] insn_o,
  output logic [31:0] insn_adr_o,
  output logic        insn_valid_o,
  input  logic        insn_ready_i,
  output logic        fetch_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] ROOM_MAX  = CW'(DEPTH - 2);
  localparam logic [31:0]   RESET_ADR = {RESET_PC[31:1], 1'b0};

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, HALT = 2'd2} state_e;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tcnt_q;
  logic          err_q;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1} state_e;
`endif

  state_e        state_q;
  logic          cyc_q;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wrptr_q, rdptr_q;
  logic [31:0]   fadr_q, hadr_q;
  logic [15:0]   mem_q [DEPTH];
  logic          push, pop, room;
  logic          unused_ok;

  always_comb begin
    pop  = (count_q != '0) && insn_ready_i;
    push = cyc_q && wb_ack_i;
    count_d = count_q;
    if (push) count_d = count_d + CW'(2);
    if (pop)  count_d = count_d - CW'(1);
    // a request is only ever launched with two free slots, so overflow cannot occur
    room = (count_d <= ROOM_MAX);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      count_q <= '0;
      wrptr_q <= '0;
      rdptr_q <= '0;
      fadr_q  <= RESET_ADR;
      hadr_q  <= RESET_ADR;
`ifdef FETCH_TIMEOUT_EN
      tcnt_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else if (flush_i) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      count_q <= '0;
      wrptr_q <= '0;
      rdptr_q <= '0;
      fadr_q  <= {flush_pc_i[31:1], 1'b0};
      hadr_q  <= {flush_pc_i[31:1], 1'b0};
`ifdef FETCH_TIMEOUT_EN
      tcnt_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      count_q <= count_d;
      if (pop) begin
        rdptr_q <= rdptr_q + AW'(1);
        hadr_q  <= hadr_q + 32'd2;
      end
      if (push) begin
        mem_q[wrptr_q]          <= wb_dat_i[31:16];
        mem_q[wrptr_q + AW'(1)] <= wb_dat_i[15:0];
        wrptr_q <= wrptr_q + AW'(2);
        fadr_q  <= fadr_q + 32'd4;
      end
      case (state_q)
        IDLE: begin
          if (room) begin
            state_q <= BUS;
            cyc_q   <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            tcnt_q  <= '0;
`endif
          end
        end
        BUS: begin
          if (push) begin
`ifdef FETCH_TIMEOUT_EN
            tcnt_q <= '0;
`endif
            if (!room) begin
              state_q <= IDLE;
              cyc_q   <= 1'b0;
            end
          end
`ifdef FETCH_TIMEOUT_EN
          else if (tcnt_q == TLAST) begin
            state_q <= HALT;
            cyc_q   <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        HALT: begin
          cyc_q <= 1'b0;
        end
`else
        end
`endif
        default: begin
          state_q <= IDLE;
          cyc_q   <= 1'b0;
        end
      endcase
    end
  end

  assign wb_adr_o     = fadr_q;
  assign wb_dat_o     = '0;
  assign wb_we_o      = 1'b0;
  assign wb_sel_o     = 2'b11;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign wb_tga_o     = cyc_q;
  assign insn_o       = mem_q[rdptr_q];
  assign insn_adr_o   = hadr_q;
  assign insn_valid_o = (count_q != '0);

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err_o = err_q;
  assign unused_ok   = &{1'b0, flush_pc_i[0]};
`else
  assign fetch_err_o = 1'b0;
  assign unused_ok   = &{1'b0, flush_pc_i[0], TIMEOUT[0]};
`endif

endmodule

// File: tb/tb_moxie_ifetch_wb.sv
// Scoreboard bench for moxie_ifetch_wb: a program-order halfword model feeds an
// expected queue on every accepted bus read; a monitor pops it on every consumed halfword.
module tb_moxie_ifetch_wb;

  logic        clk = 1'b0;
  logic        wb_rst_i, flush_i, insn_ready_i, fetch_err_o;
  logic [31:0] wb_adr_o, wb_dat_i, wb_dat_o, flush_pc_i, insn_adr_o;
  logic        wb_we_o, wb_tga_o, wb_cyc_o, wb_stb_o, wb_ack_i, insn_valid_o;
  logic [1:0]  wb_sel_o;
  logic [15:0] insn_o;
  logic        ack_en, stray_en;

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [15:0] hw;
  } ent_t;

  ent_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          pushes = 0;
  int          pops   = 0;
  logic [31:0] mfadr;

  function automatic logic [15:0] hw(input logic [31:0] a);
    if (a == 32'h1000) return 16'h1111;
    if (a == 32'h1002) return 16'h2222;
    return a[16:1] ^ a[31:16] ^ 16'h5A3C;
  endfunction

  assign wb_dat_i = {hw(wb_adr_o), hw(wb_adr_o + 32'd2)};
  assign wb_ack_i = ack_en & (wb_cyc_o | stray_en);

  moxie_ifetch_wb #(.RESET_PC(32'h0000_1000), .DEPTH(8), .TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_tga_o(wb_tga_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .flush_i(flush_i),
    .flush_pc_i(flush_pc_i), .insn_o(insn_o), .insn_adr_o(insn_adr_o),
    .insn_valid_o(insn_valid_o), .insn_ready_i(insn_ready_i), .fetch_err_o(fetch_err_o)
  );

  function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // One clock of stimulus; the model records what the DUT must buffer from this cycle.
  task automatic step(input logic rst, input logic fl, input logic [31:0] pc,
                      input logic ack, input logic stray, input logic rdy);
    @(negedge clk);
    wb_rst_i = rst; flush_i = fl; flush_pc_i = pc;
    ack_en = ack; stray_en = stray; insn_ready_i = rdy;
    if (rst) begin
      q.delete();
      mfadr = 32'h1000;
    end else if (fl) begin
      q.delete();
      mfadr = {pc[31:1], 1'b0};
    end else if (wb_cyc_o && ack) begin
      chk("fetch_adr", wb_adr_o, mfadr);
      q.push_back('{mfadr, hw(mfadr)});
      q.push_back('{mfadr + 32'd2, hw(mfadr + 32'd2)});
      mfadr = mfadr + 32'd4;
      pushes++;
      chk("occupancy_le_depth", 32'(q.size() <= 8), 32'd1);
    end
  endtask

  initial begin : monitor
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!wb_rst_i) begin
        chk("bus_tieoffs", 32'({wb_stb_o, wb_tga_o, wb_we_o, wb_sel_o, (wb_dat_o != 32'd0)}),
            32'({wb_cyc_o, wb_cyc_o, 1'b0, 2'b11, 1'b0}));
`ifndef FETCH_TIMEOUT_EN
        chk("err_tied0", 32'(fetch_err_o), 32'd0);
`endif
        if (!flush_i && insn_valid_o) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_on_empty actual=valid_with_no_expected required=no_valid");
          end else if (insn_ready_i) begin
            e = q.pop_front();
            chk("insn_adr", insn_adr_o, e.adr);
            chk("insn_data", 32'(insn_o), 32'(e.hw));
            pops++;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    int pops0;
    wb_rst_i = 1'b1; flush_i = 1'b0; flush_pc_i = '0;
    ack_en = 1'b0; stray_en = 1'b0; insn_ready_i = 1'b0;
    mfadr = 32'h1000;
    repeat (3) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    // release: DUT still shows reset state this cycle
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_valid", 32'(insn_valid_o), 32'd0);
    chk("rst_err", 32'(fetch_err_o), 32'd0);
    chk("rst_adr", wb_adr_o, 32'h1000);
    chk("rst_hadr", insn_adr_o, 32'h1000);

    // fill with consumer stalled: exactly four reads, then the bus goes quiet
    pushes = 0;
    repeat (7) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("fill_reads", 32'(pushes), 32'd4);
    chk("full_cyc_low", 32'(wb_cyc_o), 32'd0);
    chk("full_valid", 32'(insn_valid_o), 32'd1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("one_pop_no_fetch", 32'(wb_cyc_o), 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("two_pop_refetch", 32'(wb_cyc_o), 32'd1);
    chk("refetch_adr", wb_adr_o, 32'h1010);

    // ack stall: address and strobe hold
    repeat (2) begin
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      chk("stall_cyc", 32'(wb_cyc_o), 32'd1);
      chk("stall_adr", wb_adr_o, 32'h1010);
    end
    pushes = 0;
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("stall_one_push", 32'(pushes), 32'd1);

    // flush colliding with ack and pop
    n = 0;
    do begin
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      n++;
    end while (!(wb_cyc_o && insn_valid_o) && n < 20);
    chk("wait_bus_before_flush", 32'(wb_cyc_o && insn_valid_o), 32'd1);
    step(1'b0, 1'b1, 32'h2003, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("flush_valid", 32'(insn_valid_o), 32'd0);
    chk("flush_bubble", 32'(wb_cyc_o), 32'd0);
    chk("flush_hadr", insn_adr_o, 32'h2002);
    chk("flush_fadr", wb_adr_o, 32'h2002);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("flush_refetch", 32'(wb_cyc_o), 32'd1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("flush_first_valid", 32'(insn_valid_o), 32'd1);

    // randomized traffic with occasional redirects, resets and stray acks
    repeat (3000) begin
      if ($urandom_range(0, 199) == 0)
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      else
        step(1'b0, ($urandom_range(0, 99) == 0), $urandom(),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
             ($urandom_range(0, 2) != 0));
    end

`ifdef FETCH_TIMEOUT_EN
    step(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
    n = 0;
    repeat (20) begin
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      if (wb_cyc_o) n++;
    end
    chk("timeout_bus_cycles", 32'(n), 32'd4);
    chk("timeout_err", 32'(fetch_err_o), 32'd1);
    chk("timeout_cyc", 32'(wb_cyc_o), 32'd0);
    step(1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("timeout_err_cleared", 32'(fetch_err_o), 32'd0);
    chk("timeout_resume_adr", wb_adr_o, 32'd0);
`endif

    pops0 = pops;
    repeat (40) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("stream_progress", 32'(pops > pops0), 32'd1);
    repeat (20) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("drain_valid", 32'(insn_valid_o), 32'd0);
    chk("drain_queue", 32'(q.size()), 32'd0);

    @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
